// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states, width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_W = 32;

    // One-hot operation selects presented on div_op.
    localparam logic [3:0] DIV_OP_DIVW  = 4'b0001;
    localparam logic [3:0] DIV_OP_MODW  = 4'b0010;
    localparam logic [3:0] DIV_OP_DIVWU = 4'b0100;
    localparam logic [3:0] DIV_OP_MODWU = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
// Latency: 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: rem_in/dvd_bit form the shifted partial remainder, divisor is |divisor|;
//        rem_out is the next partial remainder, q_bit the produced quotient bit.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] diff;

    // The shifted remainder can reach 33 bits, so the trial subtract is 33 wide.
    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DIV_W];
    // Either branch fits in 32 bits: a kept difference is below the divisor,
    // and a restored value was already below the divisor.
    assign rem_out = q_bit ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];

endmodule

// File: rtl/divider.sv
// Iterative 32-bit divider for div.w/mod.w/div.wu/mod.wu (radix-2 restoring).
// Latency: accept in T, res_valid first high in T+33; one operation in flight.
// Backpressure: div_ready only in IDLE; result held in DONE until res_ready; div_cancel aborts.
// Ports: clk/resetn; div_valid/div_ready/div_src1/div_src2/div_op request side;
//        div_cancel flush; res_valid/res_ready/div_res result side.
module divider
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [DIV_W-1:0] div_src1,
    input  logic [DIV_W-1:0] div_src2,
    input  logic [3:0]       div_op,
    input  logic             div_cancel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DIV_W-1:0] div_res
);

    div_state_e       state;
    logic [4:0]       cnt;
    logic [DIV_W-1:0] rem_q;     // partial remainder
    logic [DIV_W-1:0] quo_q;     // dividend shifting out, quotient shifting in
    logic [DIV_W-1:0] dsr_q;     // |divisor|
    logic             q_sign;
    logic             r_sign;
    logic             mod_q;     // result selects remainder rather than quotient
    logic [DIV_W-1:0] res_q;

    logic             op_signed;
    logic             op_mod;
    logic [DIV_W-1:0] abs1;
    logic [DIV_W-1:0] abs2;
    logic [DIV_W-1:0] step_rem;
    logic             step_q;
    logic [DIV_W-1:0] fin_quo;
    logic [DIV_W-1:0] fin_rem;

    assign op_signed = |(div_op & (DIV_OP_DIVW | DIV_OP_MODW));
    assign op_mod    = |(div_op & (DIV_OP_MODW | DIV_OP_MODWU));
    assign abs1      = neg_if(div_src1, op_signed & div_src1[DIV_W-1]);
    assign abs2      = neg_if(div_src2, op_signed & div_src2[DIV_W-1]);

    div_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (quo_q[DIV_W-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Values after the final (32nd) step, with sign correction applied.
    assign fin_quo = neg_if({quo_q[DIV_W-2:0], step_q}, q_sign);
    assign fin_rem = neg_if(step_rem, r_sign);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
            mod_q  <= 1'b0;
            res_q  <= '0;
        end else if (div_cancel) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_valid) begin
                        state  <= ST_CALC;
                        cnt    <= '0;
                        rem_q  <= '0;
                        quo_q  <= abs1;
                        dsr_q  <= abs2;
                        // A zero divisor yields an all-ones quotient magnitude that
                        // must not be negated. The remainder magnitude is |src1|,
                        // and negating it by src1's sign rebuilds src1 exactly,
                        // so the remainder needs no bypass.
                        q_sign <= op_signed & (div_src1[DIV_W-1] ^ div_src2[DIV_W-1])
                                  & (div_src2 != '0);
                        r_sign <= op_signed & div_src1[DIV_W-1];
                        mod_q  <= op_mod;
                    end
                end
                ST_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[DIV_W-2:0], step_q};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_DONE;
                        res_q <= mod_q ? fin_rem : fin_quo;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign div_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign div_res   = res_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a negedge monitor
// pops and compares value and latency on each rising res_valid.
// Ports: none.
module tb_divider;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_valid;
    logic        div_ready;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic [3:0]  div_op;
    logic        div_cancel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] div_res;

    divider dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_op     (div_op),
        .div_cancel (div_cancel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .div_res    (div_res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          t;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on the first cycle of each result, then require stability.
    logic        prev_v = 1'b0;
    logic [31:0] held   = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_v = 1'b0;
            end else begin
                if (res_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%08h expected=none at cycle %0d",
                                 div_res, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("result", div_res, e.res);
                        check("latency", 32'(cyc), 32'(e.t + 33));
                    end
                    held = div_res;
                end else if (res_valid) begin
                    check("res_stable", div_res, held);
                end
                prev_v = res_valid;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        int n = 0;
        while (!div_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!div_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1 at cycle %0d", cyc);
        end
        div_valid = 1'b1;
        div_op    = op;
        div_src1  = a;
        div_src2  = b;
        if (push) sb.push_back('{exp, cyc});
        @(posedge clk); #1;
        // Scramble inputs: they must only be sampled in the accept cycle.
        div_valid = 1'b0;
        div_op    = 4'b1000;
        div_src1  = $urandom;
        div_src2  = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || res_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || res_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0 at cycle %0d", sb.size(), cyc);
            sb.delete();
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        issue(op, a, b, exp, 1'b1);
        wait_drain();
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        div_valid  = 1'b0;
        div_src1   = '0;
        div_src2   = '0;
        div_op     = 4'b0000;
        div_cancel = 1'b0;
        res_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_div_ready", {31'b0, div_ready}, 32'd1);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_div_res", div_res, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        run(DIV_OP_DIVW,  32'd7,        32'd2,        32'h00000003);
        run(DIV_OP_MODW,  32'd7,        32'd2,        32'h00000001);
        run(DIV_OP_DIVW,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run(DIV_OP_MODW,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run(DIV_OP_DIVWU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF);
        run(DIV_OP_MODWU, 32'hFFFFFFFF, 32'd2,        32'h00000001);
        run(DIV_OP_DIVW,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run(DIV_OP_MODW,  32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run(DIV_OP_DIVW,  32'h12345678, 32'h0,        32'hFFFFFFFF);
        run(DIV_OP_MODWU, 32'h12345678, 32'h0,        32'h12345678);
        run(DIV_OP_DIVW,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF);
        run(DIV_OP_MODW,  32'h80000001, 32'h0,        32'h80000001);
        run(DIV_OP_DIVW,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2);

        // Consumer stalls for 5 cycles after res_valid.
        res_ready = 1'b0;
        issue(DIV_OP_DIVWU, 32'd100, 32'd7, 32'd14, 1'b1);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_res_valid", {31'b0, res_valid}, 32'd1);
        repeat (5) begin
            check("stall_div_ready", {31'b0, div_ready}, 32'd0);
            check("stall_res_held", {31'b0, res_valid}, 32'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        wait_drain();
        run(DIV_OP_MODWU, 32'd100, 32'd7, 32'd2);

        // Cancel at T+10, then a fresh op at T+11 must finish at T+44.
        issue(DIV_OP_DIVW, 32'd100, 32'hFFFFFFF9, 32'h0, 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        div_cancel = 1'b1;
        @(posedge clk); #1;
        div_cancel = 1'b0;
        check("cancel_div_ready", {31'b0, div_ready}, 32'd1);
        check("cancel_res_valid", {31'b0, res_valid}, 32'd0);
        run(DIV_OP_MODW, 32'd100, 32'hFFFFFFF9, 32'h00000002);

        // Cancel wins over a simultaneous accept.
        div_valid  = 1'b1;
        div_op     = DIV_OP_DIVW;
        div_src1   = 32'd9;
        div_src2   = 32'd3;
        div_cancel = 1'b1;
        @(posedge clk); #1;
        div_valid  = 1'b0;
        div_cancel = 1'b0;
        check("cancel_vs_accept", {31'b0, div_ready}, 32'd1);
        run(DIV_OP_DIVWU, 32'd9, 32'd3, 32'd3);

        // Asynchronous reset in the middle of an operation.
        issue(DIV_OP_DIVW, 32'd7, 32'd2, 32'h0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        check("arst_div_ready", {31'b0, div_ready}, 32'd1);
        check("arst_res_valid", {31'b0, res_valid}, 32'd0);
        check("arst_div_res", div_res, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        run(DIV_OP_DIVW, 32'd7, 32'd2, 32'h00000003);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
